seq_detector_multi: RTL

Parametrised, multi-channel serial sequence detector. It generalises the team's fixed-pattern Mealy/Moore detectors into one block with:
- a configurable pattern and length,
- per-channel runtime Mealy/Moore output selection,
- an overlap/non-overlap mode,
- saturating per-channel hit counters.

It sits behind the debounced step-pulse generator. Each channel advances one bit per `step` and has its own bit input, output and counter.

---
 rtl/seq_detector_multi.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_detector_multi.sv
// seq_detector_multi
//   Multi-channel serial pattern detector. Each channel shifts in one bit of
//   x per step, compares the newest LEN bits against PATTERN, and reports a
//   match either combinationally (Mealy) or one step later from a registered
//   flag (Moore), selected per channel at runtime. Every channel also keeps a
//   saturating hit counter.
//
// Parameters
//   LEN      pattern length in bits (>= 2)
//   PATTERN  pattern to match; bit LEN-1 is the first bit received
//   CH       number of independent channels
//   OVERLAP  1: overlapping matches allowed, 0: history discarded after a hit
//   CNT_W    width of each hit counter
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   step     one-cycle sample enable shared by all channels
//   x        serial data bit per channel
//   mode     per-channel output select: 0 = Mealy, 1 = Moore (not registered)
//   clr_cnt  synchronous clear of all hit counters (wins over a hit)
//   z        per-channel detect output
//   hit_cnt  packed counters, channel i at [i*CNT_W +: CNT_W]
module seq_detector_multi #(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int unsigned    CH      = 2,
  parameter bit             OVERLAP = 1'b1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic [CH-1:0]       x,
  input  logic [CH-1:0]       mode,
  input  logic                clr_cnt,
  output logic [CH-1:0]       z,
  output logic [CH*CNT_W-1:0] hit_cnt
);

  localparam int unsigned    FW       = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(LEN);
  localparam logic [FW-1:0]  FILL_THR = FW'(LEN - 1);
  localparam logic [FW-1:0]  FILL_ONE = FW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [LEN-1:0]   hist_q [CH];
  logic [LEN-1:0]   hist_d [CH];
  logic [FW-1:0]    fill_q [CH];
  logic [FW-1:0]    fill_d [CH];
  logic [CNT_W-1:0] cnt_q  [CH];
  logic [CNT_W-1:0] cnt_d  [CH];
  logic [CH-1:0]    mflag_q;
  logic [CH-1:0]    mflag_d;

  logic [LEN-1:0]   cand   [CH];
  logic [CH-1:0]    hit_now;

  // Match is evaluated against the live x so Mealy outputs need no step.
  always_comb begin : match_logic
    hit_now = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      cand[i]    = {hist_q[i][LEN-2:0], x[i]};
      hit_now[i] = (fill_q[i] >= FILL_THR) && (cand[i] == PATTERN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      mflag_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        hist_q[i] <= hist_d[i];
        fill_q[i] <= fill_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      mflag_q <= mflag_d;
    end
  end

  always_comb begin : next_state
    mflag_d = mflag_q;
    for (int unsigned i = 0; i < CH; i++) begin
      hist_d[i] = hist_q[i];
      fill_d[i] = fill_q[i];
      cnt_d[i]  = cnt_q[i];
      if (step) begin
        hist_d[i]  = cand[i];
        fill_d[i]  = (fill_q[i] == FILL_MAX) ? FILL_MAX : fill_q[i] + FILL_ONE;
        mflag_d[i] = hit_now[i];
        if (hit_now[i]) begin
          if (!OVERLAP) begin
            fill_d[i] = '0;
          end
          if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      end
      // Clear is applied last so it overrides a coincident hit.
      if (clr_cnt) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin : outputs
    z       = '0;
    hit_cnt = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      z[i]                      = mode[i] ? mflag_q[i] : hit_now[i];
      hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule
